// File: rtl/ena_burst_gen_pkg.sv
// Shared types and defaults for the ena burst generator and the detector benches built around it.
package ena_burst_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_CNT_W   = 8;
  // Must stay >= 1 so consecutive bursts are always separated by at least one low cycle.
  localparam int DEF_MIN_GAP = 1;

endpackage

// File: rtl/burst_down_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement and the count never wraps below 0.
module burst_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ena_burst_gen.sv
// Generates programmable runs of consecutive-high ena separated by low gaps, and counts the
// detector's trigger responses seen while a sequence is active (including the DONE cycle).
module ena_burst_gen
  import ena_burst_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] reps,
  input  logic             trig_in,
  output logic             ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trig_cnt
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_GAP_V = CNT_W'(MIN_GAP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_m1_q, len_m1_d;
  logic [CNT_W-1:0] gap_m1_q, gap_m1_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0] gap_eff;

  logic             run_load, run_dec, run_zero;
  logic [CNT_W-1:0] run_val;
  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_val;

  assign gap_eff = (gap < MIN_GAP_V) ? MIN_GAP_V : gap;

  // Shared counter for the current high run and the current low gap.
  burst_down_cnt #(.W(CNT_W)) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (run_load),
    .dec_i      (run_dec),
    .load_val_i (run_val),
    .zero_o     (run_zero)
  );

  // Holds the bursts still to come after the current one.
  burst_down_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rep_load),
    .dec_i      (rep_dec),
    .load_val_i (rep_val),
    .zero_o     (rep_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_m1_q   <= '0;
      gap_m1_q   <= '0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_m1_q   <= len_m1_d;
      gap_m1_q   <= gap_m1_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_m1_d   = len_m1_q;
    gap_m1_d   = gap_m1_q;
    trig_cnt_d = trig_cnt_q;
    run_load   = 1'b0;
    run_dec    = 1'b0;
    run_val    = len_m1_q;
    rep_load   = 1'b0;
    rep_dec    = 1'b0;
    rep_val    = reps - ONE;

    if ((state_q != ST_IDLE) && trig_in && (trig_cnt_q != '1)) begin
      trig_cnt_d = trig_cnt_q + ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          len_m1_d   = len - ONE;
          gap_m1_d   = gap_eff - ONE;
          trig_cnt_d = '0;
          if ((len == '0) || (reps == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_HIGH;
            run_load = 1'b1;
            run_val  = len - ONE;
            rep_load = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (run_zero) begin
          if (rep_zero) begin
            state_d = ST_DONE;
          end else begin
            rep_dec  = 1'b1;
            run_load = 1'b1;
            run_val  = gap_m1_q;
            state_d  = ST_GAP;
          end
        end else begin
          run_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (run_zero) begin
          run_load = 1'b1;
          run_val  = len_m1_q;
          state_d  = ST_HIGH;
        end else begin
          run_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ena      = (state_q == ST_HIGH);
  assign busy     = (state_q == ST_HIGH) || (state_q == ST_GAP);
  assign done     = (state_q == ST_DONE);
  assign trig_cnt = trig_cnt_q;

endmodule

// File: tb/tb_ena_burst_gen.sv
// Bench for ena_burst_gen: a waveform-queue model of the generator, a 4-stage detector for
// loopback, and directed scenarios with hand-computed literal expectations.
module tb_ena_burst_gen;

  localparam int CNT_W    = 8;
  localparam int MIN_GAP  = 1;
  localparam int TRIG_MAX = 255;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] reps;
  logic             trig_in;
  logic             ena;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] trig_cnt;

  logic             loop_en;
  logic             trig_drv;
  logic [3:0]       det_q;

  int checks;
  int errors;
  logic chk_en;

  // Expected {ena,busy,done} for each future cycle of the active sequence.
  logic [2:0] exp_q[$];
  logic [2:0] cur_exp;
  int         exp_trig;

  ena_burst_gen #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .len      (len),
    .gap      (gap),
    .reps     (reps),
    .trig_in  (trig_in),
    .ena      (ena),
    .busy     (busy),
    .done     (done),
    .trig_cnt (trig_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-stage enable-chain detector: trigger once ena was high for the last 4 sampled cycles.
  always @(posedge clk) begin
    if (rst) det_q <= '0;
    else     det_q <= {det_q[2:0], ena};
  end
  assign trig_in = loop_en ? (&det_q) : trig_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by the edge the DUT is about to see.
  task automatic model_step();
    int g;
    if (rst) begin
      exp_q.delete();
      cur_exp  = 3'b000;
      exp_trig = 0;
    end else begin
      if (trig_in && (cur_exp[1] || cur_exp[0]) && exp_trig < TRIG_MAX) exp_trig++;
      if (cur_exp == 3'b000 && start && !abort) begin
        exp_trig = 0;
        g = (int'(gap) < MIN_GAP) ? MIN_GAP : int'(gap);
        if (len != 0 && reps != 0) begin
          for (int r = 0; r < int'(reps); r++) begin
            for (int i = 0; i < int'(len); i++) exp_q.push_back(3'b110);
            if (r != int'(reps) - 1)
              for (int i = 0; i < g; i++) exp_q.push_back(3'b010);
          end
        end
        exp_q.push_back(3'b001);
      end else if (cur_exp[1] && abort) begin
        exp_q.delete();
      end
      cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // compare process: every cycle, DUT outputs against the model
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("ena",      32'(ena),      32'(cur_exp[2]));
      check("busy",     32'(busy),     32'(cur_exp[1]));
      check("done",     32'(done),     32'(cur_exp[0]));
      check("trig_cnt", 32'(trig_cnt), 32'(exp_trig));
    end
  end

  // Start a sequence, record ena per cycle (bit c = cycle c after start) until done, then step to idle.
  task automatic run_seq(input int l, input int g, input int r, input int maxc,
                         output int done_cyc, output logic [63:0] pat);
    len = CNT_W'(l); gap = CNT_W'(g); reps = CNT_W'(r);
    start = 1'b1;
    cycle();
    start = 1'b0;
    pat = '0;
    done_cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      if (c < 64) pat[c] = ena;
      if (done) begin
        done_cyc = c;
        break;
      end
      cycle();
    end
    if (done_cyc < 0) check("done_timeout", 32'(done_cyc), 32'(maxc));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    logic [63:0] pat;
    int dn;

    checks = 0; errors = 0; chk_en = 1'b0;
    exp_trig = 0; cur_exp = 3'b000;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    len = '0; gap = '0; reps = '0;
    loop_en = 1'b0; trig_drv = 1'b0;
    cycle(); cycle();
    chk_en = 1'b1;
    check("rst_ena",  32'(ena),      0);
    check("rst_busy", 32'(busy),     0);
    check("rst_done", 32'(done),     0);
    check("rst_trig", 32'(trig_cnt), 0);
    rst = 1'b0;
    cycle();

    // single burst: ena cycles 1-4, done cycle 5
    run_seq(4, 2, 1, 50, dc, pat);
    check("single_done_cyc", 32'(dc), 5);
    check("single_pat", pat[31:0], 32'h0000_001E);
    check("single_idle", 32'(busy), 0);

    // multi burst: ena 1-4 and 7-10, done 11
    run_seq(4, 2, 2, 50, dc, pat);
    check("multi_done_cyc", 32'(dc), 11);
    check("multi_pat", pat[31:0], 32'h0000_079E);

    // gap clamp: 1,1,0,1,1,0,1,1 then done at 9
    run_seq(2, 0, 3, 50, dc, pat);
    check("clamp_done_cyc", 32'(dc), 9);
    check("clamp_pat", pat[31:0], 32'h0000_01B6);

    // more shapes
    run_seq(1, 1, 3, 50, dc, pat);
    check("len1_done_cyc", 32'(dc), 6);
    run_seq(3, 4, 2, 50, dc, pat);
    check("gap4_done_cyc", 32'(dc), 11);

    // zero config
    run_seq(0, 2, 3, 50, dc, pat);
    check("len0_done_cyc", 32'(dc), 1);
    check("len0_pat", pat[31:0], 0);
    run_seq(4, 2, 0, 50, dc, pat);
    check("reps0_done_cyc", 32'(dc), 1);
    check("reps0_pat", pat[31:0], 0);

    // abort in 2nd gap cycle: len=2 gap=3 reps=2, gap occupies cycles 3-5
    len = 8'd2; gap = 8'd3; reps = 8'd2;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle(); cycle();
    abort = 1'b1; cycle(); abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_ena",  32'(ena),  0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      cycle();
    end
    check("abort_no_done", 32'(dn), 0);

    // start and abort together in idle
    len = 8'd3; reps = 8'd1;
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    cycle();

    // start while busy is ignored; latched len stays 3
    len = 8'd3; gap = 8'd1; reps = 8'd1;
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    len = 8'd9; reps = 8'd5; start = 1'b1; cycle(); start = 1'b0;
    check("busy_start_ena3", 32'(ena), 1);
    cycle();
    check("busy_start_done4", 32'(done), 1);
    cycle();
    check("busy_start_idle", 32'(busy), 0);

    // reset mid-burst at the 3rd high cycle, trig_in held high so trig_cnt is non-zero
    trig_drv = 1'b1;
    len = 8'd8; gap = 8'd1; reps = 8'd1;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    check("pre_rst_trig", 32'(trig_cnt), 2);
    rst = 1'b1; cycle(); rst = 1'b0; trig_drv = 1'b0;
    check("mid_rst_ena",  32'(ena),      0);
    check("mid_rst_busy", 32'(busy),     0);
    check("mid_rst_done", 32'(done),     0);
    check("mid_rst_trig", 32'(trig_cnt), 0);
    run_seq(2, 1, 1, 50, dc, pat);
    check("post_rst_done_cyc", 32'(dc), 3);

    // loopback with the detector
    loop_en = 1'b1;
    run_seq(3, 2, 1, 50, dc, pat);
    check("loop_len3_trig", 32'(trig_cnt), 0);
    run_seq(6, 2, 1, 50, dc, pat);
    check("loop_len6_trig", 32'(trig_cnt), 3);
    loop_en = 1'b0;

    // saturation: trig_in high for 300 busy cycles
    trig_drv = 1'b1;
    len = 8'd200; gap = 8'd5; reps = 8'd2;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (300) cycle();
    check("sat_busy", 32'(busy), 1);
    check("sat_trig", 32'(trig_cnt), 255);
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (3) cycle();
    trig_drv = 1'b0;
    check("sat_hold_trig", 32'(trig_cnt), 255);
    check("sat_abort_busy", 32'(busy), 0);
    cycle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
